// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data memory.
// Access sizes, FSM states and the size-to-byte-count mapping.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    function automatic logic [3:0] size_bytes(size_t s);
        return 4'd1 << s;
    endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality check for a memory request.
// Flags unsupported size, misalignment and out-of-range accesses.
module dmem_access_check
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 512
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  size_t                 size,
    output logic                  error,
    output logic [3:0]            nbytes
);

    logic                  bad_size;
    logic                  misalign;
    logic                  too_big;
    logic [ADDR_WIDTH:0]   end_addr;

    always_comb begin
        nbytes   = size_bytes(size);
        bad_size = (size == SZ_DWORD) && (DATA_WIDTH == 32);
        // n-1 as a low-bit mask; a dword count wraps to 3'b000 - 1 = 3'b111
        misalign = |(addr[2:0] & (nbytes[2:0] - 3'd1));
        end_addr = {1'b0, addr} + (ADDR_WIDTH+1)'(nbytes);
        too_big  = end_addr > (ADDR_WIDTH+1)'(MEM_SIZE);
        error    = bad_size | misalign | too_big;
    end

endmodule

// File: rtl/data_memory_hs.sv
// Byte-addressed little-endian data memory with valid/ready channels.
// One transaction in flight; response after a fixed latency.
module data_memory_hs
    import dmem_pkg::*;
#(
    parameter int MEM_SIZE       = 512,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int LATENCY        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(MEM_SIZE);
    localparam int CW    = $clog2(LATENCY + 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [7:0]            mem_q [MEM_SIZE];

    logic                  acc_err;
    logic [3:0]            acc_n;
    logic                  accept;
    logic                  wr_en;
    logic [IDX_W-1:0]      idx;

    dmem_access_check #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) u_check (
        .addr   (req_addr),
        .size   (size_t'(req_size)),
        .error  (acc_err),
        .nbytes (acc_n)
    );

    assign accept = req_valid & req_ready_q;
    assign wr_en  = accept & req_write & ~acc_err & reset_n;
    assign idx    = req_addr[IDX_W-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_error_d = rsp_error_q;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    req_ready_d = 1'b0;
                    rsp_error_d = acc_err;
                    rsp_rdata_d = '0;
                    if (!acc_err && !req_write) begin
                        for (int i = 0; i < NB; i++) begin
                            if (4'(i) < acc_n) begin
                                rsp_rdata_d[8*i +: 8] = mem_q[idx + IDX_W'(i)];
                            end
                        end
                    end
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Stores commit on the acceptance edge, so any later load sees them
    always_ff @(posedge clk) begin
        if (!reset_n && (CLEAR_ON_RESET != 0)) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (4'(i) < acc_n) begin
                    mem_q[idx + IDX_W'(i)] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed bench for data_memory_hs: a 32-bit/latency-1 instance
// and a 64-bit/latency-4 instance driven from shared request buses.
module tb_data_memory_hs;

    logic        clk;
    logic        rst_a_n, rst_b_n;
    logic        a_req_valid, b_req_valid;
    logic        a_rsp_ready, b_rsp_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;

    logic        a_req_ready, a_rsp_valid, a_rsp_error;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_error;
    logic [63:0] b_rsp_rdata;

    int n_checks = 0;
    int n_errors = 0;

    data_memory_hs #(
        .MEM_SIZE(512), .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .LATENCY(1), .CLEAR_ON_RESET(1)
    ) u_dut_a (
        .clk       (clk),
        .reset_n   (rst_a_n),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata[31:0]),
        .rsp_valid (a_rsp_valid),
        .rsp_ready (a_rsp_ready),
        .rsp_rdata (a_rsp_rdata),
        .rsp_error (a_rsp_error)
    );

    data_memory_hs #(
        .MEM_SIZE(512), .DATA_WIDTH(64), .ADDR_WIDTH(32),
        .LATENCY(4), .CLEAR_ON_RESET(1)
    ) u_dut_b (
        .clk       (clk),
        .reset_n   (rst_b_n),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (b_rsp_ready),
        .rsp_rdata (b_rsp_rdata),
        .rsp_error (b_rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] cur_rdata(input bit sel);
        return sel ? b_rsp_rdata : {32'h0, a_rsp_rdata};
    endfunction

    // Entered #1 after a rising edge; returns #1 after the response handshake.
    task automatic txn(input bit sel, input bit wr, input logic [31:0] addr,
                       input logic [1:0] sz, input logic [63:0] wd,
                       input int hold, output logic [63:0] rd,
                       output logic err, output int lat);
        chk("req_ready_idle", sel ? b_req_ready : a_req_ready, 1);
        req_write = wr;
        req_addr  = addr;
        req_size  = sz;
        req_wdata = wd;
        if (sel) b_req_valid = 1'b1;
        else     a_req_valid = 1'b1;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        req_write   = ~wr;
        req_addr    = 32'hFFFF_FFFF;
        req_size    = 2'b00;
        req_wdata   = '1;
        lat = 1;
        while (!(sel ? b_rsp_valid : a_rsp_valid) && lat <= 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat > 20) begin
            chk("rsp_timeout", 1, 0);
            rd  = '0;
            err = 1'b0;
            return;
        end
        rd  = cur_rdata(sel);
        err = sel ? b_rsp_error : a_rsp_error;
        for (int h = 0; h < hold; h++) begin
            chk("hold_req_ready", sel ? b_req_ready : a_req_ready, 0);
            @(posedge clk);
            #1;
            chk("hold_valid", sel ? b_rsp_valid : a_rsp_valid, 1);
            chk("hold_rdata", cur_rdata(sel), rd);
            chk("hold_error", sel ? b_rsp_error : a_rsp_error, err);
        end
        chk("pre_hs_req_ready", sel ? b_req_ready : a_req_ready, 0);
        if (sel) b_rsp_ready = 1'b1;
        else     a_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        a_rsp_ready = 1'b0;
        b_rsp_ready = 1'b0;
    endtask

    logic [63:0] rd;
    logic        er;
    int          lt;
    bit          seen;

    initial begin
        rst_a_n = 0; rst_b_n = 0;
        a_req_valid = 0; b_req_valid = 0;
        a_rsp_ready = 0; b_rsp_ready = 0;
        req_write = 0; req_addr = '0; req_size = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_a_n = 1; rst_b_n = 1;

        chk("a_rst_req_ready", a_req_ready, 1);
        chk("a_rst_rsp_valid", a_rsp_valid, 0);
        chk("a_rst_rdata", a_rsp_rdata, 0);
        chk("a_rst_error", a_rsp_error, 0);
        chk("b_rst_req_ready", b_req_ready, 1);
        chk("b_rst_rsp_valid", b_rsp_valid, 0);

        // 32-bit, latency 1
        txn(0, 1, 32'h10, 2'b10, 64'hDEADBEEF, 0, rd, er, lt);
        chk("st_word_lat", lt, 1);
        chk("st_word_err", er, 0);
        chk("st_word_rdata", rd, 0);
        txn(0, 0, 32'h10, 2'b10, 0, 0, rd, er, lt);
        chk("ld_word_lat", lt, 1);
        chk("ld_word_rdata", rd, 64'hDEADBEEF);
        chk("ld_word_err", er, 0);

        txn(0, 1, 32'h21, 2'b00, 64'hFFFFFFAA, 0, rd, er, lt);
        txn(0, 1, 32'h22, 2'b01, 64'hFFFF1234, 0, rd, er, lt);
        txn(0, 0, 32'h20, 2'b10, 0, 0, rd, er, lt);
        chk("lanes_rdata", rd, 64'h1234AA00);
        txn(0, 0, 32'h22, 2'b01, 0, 0, rd, er, lt);
        chk("ld_half_rdata", rd, 64'h1234);
        txn(0, 0, 32'h21, 2'b00, 0, 0, rd, er, lt);
        chk("ld_byte_rdata", rd, 64'hAA);

        txn(0, 0, 32'h03, 2'b01, 0, 0, rd, er, lt);
        chk("mis_half_err", er, 1);
        chk("mis_half_rdata", rd, 0);
        chk("mis_half_lat", lt, 1);
        txn(0, 1, 32'h1FE, 2'b10, 64'h55555555, 0, rd, er, lt);
        chk("oor_st_err", er, 1);
        txn(0, 1, 32'h200, 2'b00, 64'h77, 0, rd, er, lt);
        chk("oor_byte_err", er, 1);
        txn(0, 1, 32'hFFFF_FFFC, 2'b10, 64'h66666666, 0, rd, er, lt);
        chk("wrap_st_err", er, 1);
        txn(0, 0, 32'h1FC, 2'b10, 0, 0, rd, er, lt);
        chk("edge_ld_err", er, 0);
        chk("edge_ld_rdata", rd, 0);
        txn(0, 1, 32'h1FF, 2'b00, 64'hC3, 0, rd, er, lt);
        chk("last_byte_err", er, 0);
        txn(0, 0, 32'h1FC, 2'b10, 0, 0, rd, er, lt);
        chk("last_byte_rdata", rd, 64'hC300_0000);
        txn(0, 1, 32'h10, 2'b11, 64'h11111111, 0, rd, er, lt);
        chk("dw32_st_err", er, 1);
        txn(0, 0, 32'h10, 2'b11, 0, 0, rd, er, lt);
        chk("dw32_ld_err", er, 1);
        chk("dw32_ld_rdata", rd, 0);
        txn(0, 0, 32'h10, 2'b10, 0, 0, rd, er, lt);
        chk("unchanged_rdata", rd, 64'hDEADBEEF);

        rst_a_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_a_n = 1;
        txn(0, 0, 32'h10, 2'b10, 0, 0, rd, er, lt);
        chk("a_clear_rdata", rd, 0);

        // 64-bit, latency 4
        txn(1, 1, 32'h08, 2'b11, 64'h0123456789ABCDEF, 0, rd, er, lt);
        chk("st_dword_lat", lt, 4);
        chk("st_dword_err", er, 0);
        txn(1, 0, 32'h0C, 2'b10, 0, 0, rd, er, lt);
        chk("ld_hi_word_rdata", rd, 64'h01234567);
        chk("ld_hi_word_lat", lt, 4);
        txn(1, 0, 32'h08, 2'b11, 0, 0, rd, er, lt);
        chk("ld_dword_rdata", rd, 64'h0123456789ABCDEF);
        txn(1, 0, 32'h04, 2'b11, 0, 0, rd, er, lt);
        chk("mis_dword_err", er, 1);
        chk("mis_dword_lat", lt, 4);
        txn(1, 0, 32'h08, 2'b10, 0, 3, rd, er, lt);
        chk("hold_ld_rdata", rd, 64'h89ABCDEF);
        chk("hold_ld_lat", lt, 4);
        chk("post_hs_req_ready", b_req_ready, 1);
        chk("post_hs_rsp_valid", b_rsp_valid, 0);

        // reset while waiting: response must never appear
        req_write = 0; req_addr = 32'h08; req_size = 2'b11;
        b_req_valid = 1;
        @(posedge clk);
        #1;
        b_req_valid = 0;
        chk("wait_req_ready", b_req_ready, 0);
        rst_b_n = 0;
        @(posedge clk);
        #1;
        rst_b_n = 1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (b_rsp_valid) seen = 1;
            @(posedge clk);
            #1;
        end
        chk("rst_wait_no_rsp", seen, 0);
        chk("rst_wait_req_ready", b_req_ready, 1);
        txn(1, 0, 32'h08, 2'b11, 0, 0, rd, er, lt);
        chk("b_clear_rdata", rd, 0);
        chk("b_clear_err", er, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_memory_hs.md
Name: data_memory_hs

Overview:
- Little-endian, byte-addressed data memory with valid/ready request and response channels.
- Parametrised data width, depth and access latency; supports byte/half/word/dword accesses.
- Checks alignment and range; flags illegal accesses with an error response and never touches memory for them.
- Sits between the LSU and storage. The LSU still performs sign extension.

Parameters:
- MEM_SIZE, 512, memory size in bytes; must be a multiple of DATA_WIDTH/8.
- DATA_WIDTH, 32, data path width; legal values are 32 and 64.
- ADDR_WIDTH, 32, request address width.
- LATENCY, 1, cycles from request acceptance to rsp_valid; must be at least 1.
- CLEAR_ON_RESET, 1, when 1 reset zeroes every byte; when 0 contents survive reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_WIDTH=64).
- req_wdata  in  DATA_WIDTH  store data; only the low 8·2^size bits are used.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_WIDTH  load data, zero-extended above the access size.
- rsp_error  out  1  access was illegal.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state goes to IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0.
  - With CLEAR_ON_RESET=1, all bytes are zeroed.
  - Reset mid-operation drops the in-flight transaction and any pending response.
  - A store already accepted has already committed.
- States:
  - IDLE: req_ready=1. A handshake (req_valid & req_ready) moves to WAIT if LATENCY>1, otherwise to RESP.
  - WAIT: counter loads LATENCY-1 at acceptance and decrements each cycle; at counter==1 move to RESP.
  - RESP: rsp_valid=1. Stay in RESP while rsp_ready=0. On rsp_ready=1 move to IDLE.
- Timing:
  - rsp_valid rises exactly LATENCY cycles after the acceptance edge.
  - Only one transaction is outstanding at a time.
  - req_ready is 0 in WAIT and RESP; a new request is accepted no earlier than the cycle after the response handshake.
- Response stability: rsp_rdata and rsp_error stay stable while rsp_valid=1 and rsp_ready=0.
- Request capture: all req_* inputs are sampled only at the handshake edge; later changes are ignored.
- Access size: n = 2^req_size bytes.
- Error conditions (any one sets error):
  - req_size=11 with DATA_WIDTH=32;
  - req_addr mod n != 0;
  - req_addr + n > MEM_SIZE, computed at ADDR_WIDTH+1 bits so wrap-around cannot hide an overflow.
- Error response: no memory write, rsp_rdata=0, rsp_error=1, same latency as a legal access.
- Store:
  - Bytes mem[addr+i] = req_wdata[8i+7:8i] for i < n.
  - Written on the acceptance edge. Other bytes are unchanged.
  - rsp_rdata=0.
- Load:
  - rsp_rdata[8i+7:8i] = mem[addr+i] for i < n; upper bits are 0.
  - Captured on the acceptance edge.
  - Stores always commit before any later load.

Decomposition:
- Package dmem_pkg holds:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD);
  - state_t enum (IDLE, WAIT, RESP);
  - a function returning the byte count for a size_t.
- One sub-module, dmem_access_check: combinational; takes addr and size, returns the error flag and byte count.
- Storage array, FSM and latency counter stay in the top module.

Test Plan:
- LATENCY=1, DATA_WIDTH=32:
  - store word 0xDEADBEEF @0x10, then load word @0x10 -> rdata 0xDEADBEEF, error 0.
  - rsp_valid asserts exactly 1 cycle after each acceptance.
- Byte/half lanes: store byte 0xAA @0x21, then half 0x1234 @0x22, then load word @0x20 -> rdata 0x1234AA00.
- Misaligned/out-of-range cases, each giving rsp_error=1, rdata 0, and memory unchanged on re-read:
  - load half @0x03;
  - store word @0x1FE;
  - size 11 with DATA_WIDTH=32.
- LATENCY=4 with rsp_ready held low for 3 cycles:
  - rsp_valid rises 4 cycles after acceptance, response data holds for 3 cycles;
  - req_ready stays 0 until the cycle after the rsp handshake.
- DATA_WIDTH=64: store dword 0x0123456789ABCDEF @0x08, load word @0x0C -> 0x01234567.
- Reset cases:
  - reset_n low during WAIT -> rsp_valid never asserts, req_ready=1 after reset.
  - With CLEAR_ON_RESET=1, load @0x10 -> 0.
